// File: rtl/snn_class_decoder.sv
// -----------------------------------------------------------------------------
// snn_class_decoder
//   Output stage for the spiking network. It counts output-layer spikes per
//   class over a fixed number of timesteps, then scans the counts one class
//   per cycle and reports the argmax. The result and status flags are held
//   until the next accepted start.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          asynchronous reset, active low
//   start_i          begin a new inference (accepted only in IDLE or DONE)
//   spike_valid_i    spike_addr_i carries an output spike this cycle
//   spike_addr_i     index of the output neuron that spiked
//   timestep_done_i  one-cycle pulse ending the current timestep
//   count_sel_i      class selected for count_out_o
//   count_out_o      counter of class count_sel_i (0 when out of range)
//   class_out_o      winning class index
//   class_valid_o    class_out_o valid, held until next accepted start
//   busy_o           high in CLEAR, ACCUM and SCAN
//   no_spike_o       every counter was zero at the end of the scan
//   addr_err_o       sticky: an out-of-range spike address was seen
//   sat_flag_o       sticky: an increment hit a saturated counter
// -----------------------------------------------------------------------------
module snn_class_decoder #(
    parameter int size_spike    = 10,
    parameter int num_classes   = 10,
    parameter int num_timesteps = 8,
    parameter int size_count    = 8,
    parameter int size_class    = $clog2(num_classes)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  spike_valid_i,
    input  logic [size_spike-1:0] spike_addr_i,
    input  logic                  timestep_done_i,
    input  logic [size_class-1:0] count_sel_i,
    output logic [size_count-1:0] count_out_o,
    output logic [size_class-1:0] class_out_o,
    output logic                  class_valid_o,
    output logic                  busy_o,
    output logic                  no_spike_o,
    output logic                  addr_err_o,
    output logic                  sat_flag_o
);

    localparam int ts_w = $clog2(num_timesteps + 1);
    localparam logic [size_count-1:0] cnt_max = '1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_SCAN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [size_count-1:0] cnt_q [num_classes];
    logic [size_count-1:0] cnt_d [num_classes];
    logic [ts_w-1:0]       ts_q, ts_d;
    logic [size_class-1:0] scan_idx_q, scan_idx_d;
    logic [size_count-1:0] max_val_q, max_val_d;
    logic [size_class-1:0] max_idx_q, max_idx_d;
    logic [size_class-1:0] class_out_q, class_out_d;
    logic                  class_valid_q, class_valid_d;
    logic                  no_spike_q, no_spike_d;
    logic                  addr_err_q, addr_err_d;
    logic                  sat_flag_q, sat_flag_d;

    logic [size_count-1:0] scan_val;
    logic [size_count-1:0] cand_val;
    logic [size_class-1:0] cand_idx;

    // Host read port: a compare-per-entry mux, so out-of-range selects read 0.
    always_comb begin
        count_out_o = '0;
        for (int i = 0; i < num_classes; i++) begin
            if (count_sel_i == size_class'(i)) count_out_o = cnt_q[i];
        end
    end

    // Counter under inspection during SCAN.
    always_comb begin
        scan_val = '0;
        for (int i = 0; i < num_classes; i++) begin
            if (scan_idx_q == size_class'(i)) scan_val = cnt_q[i];
        end
    end

    // Running max including this cycle's compare. Index 0 seeds the max;
    // later entries win only when strictly greater, so ties keep the lowest.
    always_comb begin
        cand_val = max_val_q;
        cand_idx = max_idx_q;
        if (scan_idx_q == '0 || scan_val > max_val_q) begin
            cand_val = scan_val;
            cand_idx = scan_idx_q;
        end
    end

    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ts_d          = ts_q;
        scan_idx_d    = scan_idx_q;
        max_val_d     = max_val_q;
        max_idx_d     = max_idx_q;
        class_out_d   = class_out_q;
        class_valid_d = class_valid_q;
        no_spike_d    = no_spike_q;
        addr_err_d    = addr_err_q;
        sat_flag_d    = sat_flag_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) state_d = S_CLEAR;
            end

            S_CLEAR: begin
                for (int i = 0; i < num_classes; i++) cnt_d[i] = '0;
                ts_d          = '0;
                scan_idx_d    = '0;
                addr_err_d    = 1'b0;
                sat_flag_d    = 1'b0;
                no_spike_d    = 1'b0;
                class_valid_d = 1'b0;
                state_d       = S_ACCUM;
            end

            S_ACCUM: begin
                if (spike_valid_i) begin
                    if (spike_addr_i < size_spike'(num_classes)) begin
                        for (int i = 0; i < num_classes; i++) begin
                            if (spike_addr_i == size_spike'(i)) begin
                                if (cnt_q[i] == cnt_max) sat_flag_d = 1'b1;
                                else                     cnt_d[i]   = cnt_q[i] + 1'b1;
                            end
                        end
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                // A spike in the same cycle as the final timestep_done is
                // still counted above before leaving ACCUM.
                if (timestep_done_i) begin
                    ts_d = ts_q + 1'b1;
                    if (ts_q == ts_w'(num_timesteps - 1)) begin
                        scan_idx_d = '0;
                        state_d    = S_SCAN;
                    end
                end
            end

            S_SCAN: begin
                max_val_d = cand_val;
                max_idx_d = cand_idx;
                if (scan_idx_q == size_class'(num_classes - 1)) begin
                    class_out_d   = cand_idx;
                    no_spike_d    = (cand_val == '0);
                    class_valid_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the counters are a handful of flops, not a RAM, so they take the
    // async reset like the rest of the state and an abort leaves nothing behind.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < num_classes; i++) cnt_q[i] <= '0;
            ts_q          <= '0;
            scan_idx_q    <= '0;
            max_val_q     <= '0;
            max_idx_q     <= '0;
            class_out_q   <= '0;
            class_valid_q <= 1'b0;
            no_spike_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            sat_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ts_q          <= ts_d;
            scan_idx_q    <= scan_idx_d;
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
            class_out_q   <= class_out_d;
            class_valid_q <= class_valid_d;
            no_spike_q    <= no_spike_d;
            addr_err_q    <= addr_err_d;
            sat_flag_q    <= sat_flag_d;
        end
    end

    assign class_out_o   = class_out_q;
    assign class_valid_o = class_valid_q;
    assign no_spike_o    = no_spike_q;
    assign addr_err_o    = addr_err_q;
    assign sat_flag_o    = sat_flag_q;
    assign busy_o        = (state_q == S_CLEAR) || (state_q == S_ACCUM) || (state_q == S_SCAN);

endmodule
